// File: rtl/max7219_rx.sv
// -----------------------------------------------------------------------------
// max7219_rx
//
// Receiver for the MAX7219 three-wire display link (max_sck / max_load /
// max_din). The link is oversampled on the system clock, 16-bit frames are
// decoded into a shadow copy of the MAX7219 register file, and the digit and
// control registers are exposed for checking display traffic without the
// physical driver.
//
// Ports:
//   clock        in   system clock, sole clock domain
//   reset        in   synchronous, active-high; clears all state
//   max_sck      in   serial clock (asynchronous)
//   max_load     in   latch strobe (asynchronous)
//   max_din      in   serial data, MSB first (asynchronous)
//   rd_addr      in   [2:0] digit register index for readback
//   rd_data      out  [7:0] registered contents of digit rd_addr (1-cycle latency)
//   decode_mode  out  [7:0] register 0x9
//   intensity    out  [3:0] register 0xA bits [3:0]
//   scan_limit   out  [2:0] register 0xB bits [2:0]
//   shutdown_n   out  register 0xC bit 0 (0 = shutdown)
//   display_test out  register 0xF bit 0
//   frame_valid  out  one-cycle pulse when a frame is accepted
//   frame_addr   out  [3:0] address of the last accepted frame
//   frame_data   out  [7:0] data of the last accepted frame
//   frame_err    out  one-cycle pulse when a frame is rejected
//
// Configuration macro:
//   MAX7219_RX_STRICT_EN  when defined, a frame is accepted only with exactly
//                         16 bits shifted; otherwise 16 or more bits are
//                         accepted using the last 16 (daisy-chain behaviour).
// -----------------------------------------------------------------------------
module max7219_rx (
   input  logic       clock,
   input  logic       reset,
   input  logic       max_sck,
   input  logic       max_load,
   input  logic       max_din,
   input  logic [2:0] rd_addr,
   output logic [7:0] rd_data,
   output logic [7:0] decode_mode,
   output logic [3:0] intensity,
   output logic [2:0] scan_limit,
   output logic       shutdown_n,
   output logic       display_test,
   output logic       frame_valid,
   output logic [3:0] frame_addr,
   output logic [7:0] frame_data,
   output logic       frame_err
);

   // Synchronizer chains: [0] and [1] form the 2-FF synchronizer, [2] is the
   // history flop used for rise detection.
   logic [2:0] sck_sync;
   logic [2:0] load_sync;
   logic [2:0] din_sync;

   // Only the low 12 bits of a frame are ever decoded (address + data); the
   // top nibble of the 16-bit word is ignored, so it is not stored.
   logic [11:0] shreg;
   logic [4:0]  bitcnt;

   logic [7:0] digits [8];

   logic        sck_rise;
   logic        load_rise;
   logic [11:0] shreg_next;
   logic [4:0]  bitcnt_next;
   logic        frame_ok;
   logic        accept;
   logic        reject;
   logic [3:0]  dec_addr;
   logic [7:0]  dec_data;

   assign sck_rise  = sck_sync[1]  & ~sck_sync[2];
   assign load_rise = load_sync[1] & ~load_sync[2];

   // The shift is resolved first so a LOAD rise in the same cycle as the
   // final SCK rise latches the completed frame.
   always_comb begin
      // NOTE: every combinational output gets a default first so no latch is inferred.
      shreg_next  = shreg;
      bitcnt_next = bitcnt;
      if (sck_rise) begin
         shreg_next = {shreg[10:0], din_sync[1]};
         if (bitcnt != 5'd31)
            bitcnt_next = bitcnt + 5'd1;
      end
`ifdef MAX7219_RX_STRICT_EN
      frame_ok = (bitcnt_next == 5'd16);
`else
      frame_ok = (bitcnt_next >= 5'd16);
`endif
      accept   = load_rise &  frame_ok;
      reject   = load_rise & ~frame_ok;
      dec_addr = shreg_next[11:8];
      dec_data = shreg_next[7:0];
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         sck_sync     <= '0;
         load_sync    <= '0;
         din_sync     <= '0;
         shreg        <= '0;
         bitcnt       <= '0;
         // NOTE: the digit store is a small register bank, not a RAM, so it is
         // cleared on reset like any other state.
         for (int i = 0; i < 8; i++)
            digits[i] <= 8'h00;
         decode_mode  <= 8'h00;
         intensity    <= 4'h0;
         scan_limit   <= 3'd0;
         shutdown_n   <= 1'b0;
         display_test <= 1'b0;
         rd_data      <= 8'h00;
         frame_valid  <= 1'b0;
         frame_err    <= 1'b0;
         frame_addr   <= 4'h0;
         frame_data   <= 8'h00;
      end else begin
         // NOTE: sequential state uses non-blocking assignments only, so every
         // flop samples the pre-edge values of its sources.
         sck_sync    <= {sck_sync[1:0],  max_sck};
         load_sync   <= {load_sync[1:0], max_load};
         din_sync    <= {din_sync[1:0],  max_din};

         shreg       <= shreg_next;
         bitcnt      <= load_rise ? 5'd0 : bitcnt_next;
         frame_valid <= accept;
         frame_err   <= reject;

         // Reads the pre-write value when the same digit is written this cycle.
         rd_data     <= digits[rd_addr];

         if (accept) begin
            frame_addr <= dec_addr;
            frame_data <= dec_data;
            for (int i = 0; i < 8; i++)
               if (dec_addr == 4'(i + 1))
                  digits[i] <= dec_data;
            case (dec_addr)
               4'h9:    decode_mode  <= dec_data;
               4'hA:    intensity    <= dec_data[3:0];
               4'hB:    scan_limit   <= dec_data[2:0];
               4'hC:    shutdown_n   <= dec_data[0];
               4'hF:    display_test <= dec_data[0];
               default: ; // no-op, digits, and 0xD/0xE write nothing here
            endcase
         end
      end
   end

endmodule

// File: tb/tb_max7219_rx.sv
// -----------------------------------------------------------------------------
// tb_max7219_rx
//
// Directed self-checking bench for max7219_rx. Frames are bit-banged with
// generous phase widths; pulse outputs are counted per high cycle so that
// both occurrence and one-cycle width are checked.
// -----------------------------------------------------------------------------
module tb_max7219_rx;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       max_sck = 1'b0;
   logic       max_load = 1'b0;
   logic       max_din = 1'b0;
   logic [2:0] rd_addr = 3'd0;
   logic [7:0] rd_data;
   logic [7:0] decode_mode;
   logic [3:0] intensity;
   logic [2:0] scan_limit;
   logic       shutdown_n;
   logic       display_test;
   logic       frame_valid;
   logic [3:0] frame_addr;
   logic [7:0] frame_data;
   logic       frame_err;

   int total = 0;
   int bad   = 0;
   int valid_hi = 0;
   int err_hi   = 0;

   max7219_rx dut (
      .clock        (clock),
      .reset        (reset),
      .max_sck      (max_sck),
      .max_load     (max_load),
      .max_din      (max_din),
      .rd_addr      (rd_addr),
      .rd_data      (rd_data),
      .decode_mode  (decode_mode),
      .intensity    (intensity),
      .scan_limit   (scan_limit),
      .shutdown_n   (shutdown_n),
      .display_test (display_test),
      .frame_valid  (frame_valid),
      .frame_addr   (frame_addr),
      .frame_data   (frame_data),
      .frame_err    (frame_err)
   );

   always #5 clock = ~clock;

   // Count high cycles of each pulse, sampled away from the active edge.
   always @(negedge clock) begin
      if (frame_valid) valid_hi++;
      if (frame_err)   err_hi++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance n clock edges, then settle 1 time unit past the edge.
   task automatic tick(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   // Shift the low nbits of value, MSB first.
   task automatic send_bits(input logic [31:0] value, input int nbits);
      for (int i = nbits - 1; i >= 0; i--) begin
         max_din = value[i];
         tick(3);
         max_sck = 1'b1;
         tick(3);
         max_sck = 1'b0;
         tick(1);
      end
      tick(2);
   endtask

   task automatic pulse_load();
      max_load = 1'b1;
      tick(3);
      max_load = 1'b0;
      tick(4);
   endtask

   task automatic send_frame(input logic [15:0] word);
      send_bits({16'h0, word}, 16);
      pulse_load();
   endtask

   int v0, e0;

   initial begin
      tick(3);
      reset = 1'b0;
      tick(2);

      // Reset state
      check("rst_decode_mode", decode_mode, 8'h00);
      check("rst_intensity", intensity, 4'h0);
      check("rst_scan_limit", scan_limit, 3'd0);
      check("rst_shutdown_n", shutdown_n, 1'b0);
      check("rst_display_test", display_test, 1'b0);
      check("rst_rd_data", rd_data, 8'h00);
      check("rst_frame_addr", frame_addr, 4'h0);
      check("rst_frame_data", frame_data, 8'h00);
      check("rst_pulses", valid_hi + err_hi, 0);

      // Shutdown frame 0x0C01
      send_frame(16'h0C01);
      check("sd_valid_cycles", valid_hi, 1);
      check("sd_err_cycles", err_hi, 0);
      check("sd_frame_addr", frame_addr, 4'hC);
      check("sd_frame_data", frame_data, 8'h01);
      check("sd_shutdown_n", shutdown_n, 1'b1);
      check("sd_intensity", intensity, 4'h0);
      check("sd_decode_mode", decode_mode, 8'h00);
      check("sd_display_test", display_test, 1'b0);

      // Digit 3 write and readback of all digits
      send_frame(16'h0455);
      check("dig_valid_cycles", valid_hi, 2);
      for (int a = 0; a < 8; a++) begin
         rd_addr = 3'(a);
         tick(1);
         check($sformatf("dig_rd%0d", a), rd_data, (a == 3) ? 8'h55 : 8'h00);
      end

      // Short frame (15 bits of 0x0A0F) is rejected
      send_bits(32'h0A0F, 15);
      pulse_load();
      check("short_err_cycles", err_hi, 1);
      check("short_valid_cycles", valid_hi, 2);
      check("short_intensity", intensity, 4'h0);
      check("short_frame_addr", frame_addr, 4'h4);
      send_frame(16'h0A0F);
      check("int_intensity", intensity, 4'hF);
      check("int_valid_cycles", valid_hi, 3);

      // 17-bit frame: leading 1 then 0x0B07
      v0 = valid_hi;
      e0 = err_hi;
      send_bits(32'h1_0B07, 17);
      pulse_load();
`ifdef MAX7219_RX_STRICT_EN
      check("long_err", err_hi - e0, 1);
      check("long_valid", valid_hi - v0, 0);
      check("long_scan_limit", scan_limit, 3'd0);
`else
      check("long_err", err_hi - e0, 0);
      check("long_valid", valid_hi - v0, 1);
      check("long_scan_limit", scan_limit, 3'd7);
`endif

      // Final SCK rise and LOAD rise together for 0x0F01
      v0 = valid_hi;
      e0 = err_hi;
      send_bits(32'h0F01 >> 1, 15);
      max_din = 1'b1;
      tick(3);
      max_sck  = 1'b1;
      max_load = 1'b1;
      tick(3);
      max_sck  = 1'b0;
      max_load = 1'b0;
      tick(4);
      check("same_valid", valid_hi - v0, 1);
      check("same_err", err_hi - e0, 0);
      check("same_display_test", display_test, 1'b1);
      check("same_frame_addr", frame_addr, 4'hF);

      // Partial frame discarded by reset
      v0 = valid_hi;
      e0 = err_hi;
      send_bits(32'h09, 8);
      reset = 1'b1;
      tick(1);
      reset = 1'b0;
      tick(1);
      check("rstmid_shutdown_n", shutdown_n, 1'b0);
      check("rstmid_frame_addr", frame_addr, 4'h0);
      send_frame(16'h0107);
      check("rstmid_valid", valid_hi - v0, 1);
      check("rstmid_err", err_hi - e0, 0);
      check("rstmid_frame_addr2", frame_addr, 4'h1);
      check("rstmid_frame_data", frame_data, 8'h07);
      check("rstmid_decode_mode", decode_mode, 8'h00);
      rd_addr = 3'd0;
      tick(1);
      check("rstmid_digit0", rd_data, 8'h07);
      rd_addr = 3'd3;
      tick(1);
      check("rstmid_digit3", rd_data, 8'h00);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
